// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the IF stage: FSM state encodings, reset/flush
// instruction and the sequential PC step.
package instruction_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam logic [31:0] PC_INCR           = 32'd4;

    // Redirect addresses are word aligned; the low two bits are dropped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, issues word reads over the busywait interface and
// fills the IF/ID register, with a one-entry hold buffer and branch discard.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         STALL,
    input  logic         BRANCH_TAKEN,
    input  logic [31:0]  BRANCH_TARGET,
    output logic         IMEM_READ,
    output logic [31:0]  IMEM_ADDR,
    input  logic [31:0]  IMEM_READDATA,
    input  logic         IMEM_BUSYWAIT,
    output logic [31:0]  ID_INSTRUCTION,
    output logic [31:0]  ID_PC,
    output logic         ID_VALID,
    output fetch_state_t dbg_state
);

    // Memory handshake: a request is IMEM_READ=1 with IMEM_ADDR; it completes
    // in the first cycle where IMEM_BUSYWAIT=0, and IMEM_READDATA is sampled
    // only then. Address stays fixed until completion (or reset/redirect).

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  target_reg;
    logic [31:0]  buf_data;
    logic         buf_valid;
    logic         completion;

    assign IMEM_ADDR  = pc;
    assign IMEM_READ  = !RESET && (state != ST_HOLD);
    assign completion = IMEM_READ && !IMEM_BUSYWAIT;
    assign dbg_state  = state;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state          <= ST_FETCH;
            pc             <= RESET_PC;
            target_reg     <= RESET_PC;
            buf_data       <= NOP_INSTR;
            buf_valid      <= 1'b0;
            ID_INSTRUCTION <= NOP_INSTR;
            ID_PC          <= 32'h0000_0000;
            ID_VALID       <= 1'b0;
        end else if (BRANCH_TAKEN) begin
            ID_VALID       <= 1'b0;
            ID_INSTRUCTION <= NOP_INSTR;
            buf_valid      <= 1'b0;
            // A wrong-path access still in flight must finish before the PC moves.
            if (IMEM_BUSYWAIT && state != ST_HOLD) begin
                target_reg <= align_word(BRANCH_TARGET);
                state      <= ST_DISCARD;
            end else begin
                pc    <= align_word(BRANCH_TARGET);
                state <= ST_FETCH;
            end
        end else begin
            case (state)
                ST_FETCH: begin
                    if (completion) begin
                        if (!STALL) begin
                            ID_INSTRUCTION <= IMEM_READDATA;
                            ID_PC          <= pc;
                            ID_VALID       <= 1'b1;
                            pc             <= pc + PC_INCR;
                        end else begin
                            buf_data  <= IMEM_READDATA;
                            buf_valid <= 1'b1;
                            state     <= ST_HOLD;
                        end
                    end else if (!STALL) begin
                        ID_VALID <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (!STALL) begin
                        ID_INSTRUCTION <= buf_data;
                        ID_PC          <= pc;
                        ID_VALID       <= 1'b1;
                        pc             <= pc + PC_INCR;
                        buf_valid      <= 1'b0;
                        state          <= ST_FETCH;
                    end
                end
                ST_DISCARD: begin
                    ID_VALID <= 1'b0;
                    if (completion) begin
                        pc    <= target_reg;
                        state <= ST_FETCH;
                    end
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a combinational memory model.
module tb_instruction_fetch_unit;
    import instruction_fetch_unit_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic         clk;
    logic         rst;
    logic         stall;
    logic         branch_taken;
    logic [31:0]  branch_target;
    logic         imem_read;
    logic [31:0]  imem_addr;
    logic [31:0]  imem_readdata;
    logic         imem_busywait;
    logic [31:0]  id_instruction;
    logic [31:0]  id_pc;
    logic         id_valid;
    fetch_state_t dbg_state;

    int pass_cnt  = 0;
    int total_cnt = 0;

    instruction_fetch_unit dut (
        .CLK           (clk),
        .RESET         (rst),
        .STALL         (stall),
        .BRANCH_TAKEN  (branch_taken),
        .BRANCH_TARGET (branch_target),
        .IMEM_READ     (imem_read),
        .IMEM_ADDR     (imem_addr),
        .IMEM_READDATA (imem_readdata),
        .IMEM_BUSYWAIT (imem_busywait),
        .ID_INSTRUCTION(id_instruction),
        .ID_PC         (id_pc),
        .ID_VALID      (id_valid),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign imem_readdata = word_at(imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        imem_busywait = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; imem_busywait = 1'b0;
        tick();
        total_cnt++; if (imem_read !== 1'b0) $display("FAIL reset_read: got %b want 0", imem_read); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", imem_addr); else pass_cnt++;
        total_cnt++; if (id_instruction !== NOP) $display("FAIL reset_instr: got %h want %h", id_instruction, NOP); else pass_cnt++;
        total_cnt++; if (id_pc !== 32'h0) $display("FAIL reset_idpc: got %h want 0", id_pc); else pass_cnt++;
        total_cnt++; if (id_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", id_valid); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (imem_read !== 1'b1) $display("FAIL reset_first_read: got %b want 1", imem_read); else pass_cnt++;
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            total_cnt++;
            if (id_pc !== 32'(4 * i) || id_valid !== 1'b1 || id_instruction !== word_at(32'(4 * i)))
                $display("FAIL zero_wait_%0d: got pc=%h v=%b i=%h want pc=%h v=1 i=%h",
                         i, id_pc, id_valid, id_instruction, 32'(4 * i), word_at(32'(4 * i)));
            else pass_cnt++;
        end
    endtask

    task automatic test_busywait();
        do_reset();
        imem_busywait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total_cnt++;
            if (imem_addr !== 32'h0 || id_valid !== 1'b0 || imem_read !== 1'b1)
                $display("FAIL busy_wait_%0d: got a=%h v=%b r=%b want a=0 v=0 r=1", i, imem_addr, id_valid, imem_read);
            else pass_cnt++;
        end
        imem_busywait = 1'b0;
        tick();
        total_cnt++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0 || imem_addr !== 32'h4)
            $display("FAIL busy_done: got v=%b pc=%h a=%h want v=1 pc=0 a=4", id_valid, id_pc, imem_addr);
        else pass_cnt++;
        imem_busywait = 1'b1;
        tick();
        total_cnt++; if (id_valid !== 1'b0) $display("FAIL busy_bubble: got %b want 0", id_valid); else pass_cnt++;
        total_cnt++; if (imem_addr !== 32'h4) $display("FAIL busy_addr_hold: got %h want 4", imem_addr); else pass_cnt++;
        imem_busywait = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total_cnt++;
            if (id_pc !== 32'h4 || id_instruction !== word_at(32'h4) || id_valid !== 1'b1)
                $display("FAIL stall_hold_%0d: got pc=%h i=%h v=%b want pc=4", i, id_pc, id_instruction, id_valid);
            else pass_cnt++;
            total_cnt++;
            if (imem_read !== 1'b0 || dbg_state !== ST_HOLD)
                $display("FAIL stall_read_%0d: got r=%b s=%0d want r=0 s=%0d", i, imem_read, dbg_state, ST_HOLD);
            else pass_cnt++;
        end
        stall = 1'b0;
        tick();
        total_cnt++;
        if (id_pc !== 32'h8 || id_instruction !== word_at(32'h8) || id_valid !== 1'b1)
            $display("FAIL stall_release: got pc=%h i=%h v=%b want pc=8 i=%h", id_pc, id_instruction, id_valid, word_at(32'h8));
        else pass_cnt++;
        total_cnt++;
        if (imem_addr !== 32'hC || imem_read !== 1'b1)
            $display("FAIL stall_next_addr: got a=%h r=%b want a=c r=1", imem_addr, imem_read);
        else pass_cnt++;
    endtask

    task automatic test_branch_discard();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        imem_busywait = 1'b1;
        tick();
        branch_taken  = 1'b1;
        branch_target = 32'h103;
        tick();
        branch_taken = 1'b0;
        total_cnt++;
        if (imem_addr !== 32'h10 || dbg_state !== ST_DISCARD || id_valid !== 1'b0 || id_instruction !== NOP)
            $display("FAIL br_discard_enter: got a=%h s=%0d v=%b i=%h", imem_addr, dbg_state, id_valid, id_instruction);
        else pass_cnt++;
        tick();
        total_cnt++; if (imem_addr !== 32'h10) $display("FAIL br_addr_stable: got %h want 10", imem_addr); else pass_cnt++;
        imem_busywait = 1'b0;
        tick();
        total_cnt++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h100)
            $display("FAIL br_drop: got v=%b a=%h want v=0 a=100", id_valid, imem_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (id_valid !== 1'b1 || id_pc !== 32'h100 || id_instruction !== word_at(32'h100))
            $display("FAIL br_target: got v=%b pc=%h i=%h want pc=100", id_valid, id_pc, id_instruction);
        else pass_cnt++;
    endtask

    task automatic test_branch_in_hold();
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        tick();
        total_cnt++; if (dbg_state !== ST_HOLD) $display("FAIL hold_enter: got %0d want %0d", dbg_state, ST_HOLD); else pass_cnt++;
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        total_cnt++;
        if (id_valid !== 1'b0 || id_instruction !== NOP || imem_addr !== 32'h200 || imem_read !== 1'b1)
            $display("FAIL hold_flush: got v=%b i=%h a=%h r=%b", id_valid, id_instruction, imem_addr, imem_read);
        else pass_cnt++;
        stall = 1'b0;
        tick();
        total_cnt++;
        if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instruction !== word_at(32'h200))
            $display("FAIL hold_target: got v=%b pc=%h i=%h want pc=200", id_valid, id_pc, id_instruction);
        else pass_cnt++;
    endtask

    task automatic test_branch_same_cycle_and_wrap();
        do_reset();
        tick();
        // zero-wait branch: word completing this cycle at 0x4 is dropped
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        total_cnt++;
        if (id_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC)
            $display("FAIL br_same_cycle: got v=%b a=%h want v=0 a=fffffffc", id_valid, imem_addr);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (id_pc !== 32'hFFFF_FFFC || id_valid !== 1'b1 || imem_addr !== 32'h0)
            $display("FAIL pc_wrap: got pc=%h v=%b a=%h want pc=fffffffc a=0", id_pc, id_valid, imem_addr);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        tick();
        tick();
        imem_busywait = 1'b1;
        tick();
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if (imem_read !== 1'b0 || imem_addr !== 32'h0 || id_valid !== 1'b0 || dbg_state !== ST_FETCH)
            $display("FAIL reset_mid: got r=%b a=%h v=%b s=%0d", imem_read, imem_addr, id_valid, dbg_state);
        else pass_cnt++;
        imem_busywait = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        total_cnt++;
        if (id_pc !== 32'h0 || id_valid !== 1'b1)
            $display("FAIL reset_mid_restart: got pc=%h v=%b want pc=0 v=1", id_pc, id_valid);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_busywait();
        test_stall();
        test_branch_discard();
        test_branch_in_hold();
        test_branch_same_cycle_and_wrap();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
